// File: rtl/countdown_ctrl_pkg.sv
// Shared definitions for the mm:ss countdown controller and its BCD counters.
package countdown_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_ALARM = 2'd3
    } state_t;

    localparam int          BCD_DIGIT_W = 4;
    localparam logic [7:0]  SEC_MAX     = 8'h59;

    // Convert a small decimal constant (0..99) to two packed BCD digits.
    function automatic logic [7:0] int_to_bcd(input int v);
        logic [BCD_DIGIT_W-1:0] hi;
        logic [BCD_DIGIT_W-1:0] lo;
        hi = BCD_DIGIT_W'(v / 10);
        lo = BCD_DIGIT_W'(v % 10);
        return {hi, lo};
    endfunction

    // Next value up, with carry from the low digit into the high digit.
    function automatic logic [7:0] bcd_up(input logic [7:0] v);
        logic [BCD_DIGIT_W-1:0] hi;
        logic [BCD_DIGIT_W-1:0] lo;
        hi = v[7:4];
        lo = v[3:0];
        if (lo == 4'd9) begin
            return {hi + 4'd1, 4'd0};
        end
        return {hi, lo + 4'd1};
    endfunction

    // Next value down, borrowing x0 -> (x-1)9.
    function automatic logic [7:0] bcd_down(input logic [7:0] v);
        logic [BCD_DIGIT_W-1:0] hi;
        logic [BCD_DIGIT_W-1:0] lo;
        hi = v[7:4];
        lo = v[3:0];
        if (lo == 4'd0) begin
            return {hi - 4'd1, 4'd9};
        end
        return {hi, lo - 4'd1};
    endfunction

endpackage

// File: rtl/countdown_ctrl_bcd_pair_counter.sv
// Two-digit BCD up/down counter wrapping between 00 and MAX.
// borrow is a same-cycle indication that a decrement is wrapping 00 -> MAX,
// so a more significant counter can take its decrement on the same edge.
module bcd_pair_counter
    import countdown_ctrl_pkg::*;
#(
    parameter logic [7:0] MAX = SEC_MAX
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       dec,
    input  logic       clr,
    output logic [7:0] value,
    output logic       is_zero,
    output logic       borrow
);

    logic [7:0] value_d;

    // Next value: clear beats decrement beats increment.
    always_comb begin
        value_d = value;
        if (clr) begin
            value_d = 8'h00;
        end else if (dec) begin
            value_d = (value == 8'h00) ? MAX : bcd_down(value);
        end else if (inc) begin
            value_d = (value == MAX) ? 8'h00 : bcd_up(value);
        end
    end

    // Value register.
    always_ff @(posedge clk) begin
        if (rst) begin
            value <= 8'h00;
        end else begin
            value <= value_d;
        end
    end

    assign is_zero = (value == 8'h00);
    assign borrow  = dec && !clr && (value == 8'h00);

endmodule

// File: rtl/countdown_ctrl.sv
// Minutes:seconds countdown controller.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | setting mm:ss with the inc buttons, timer stopped
//   RUN   | counting down one second per tick, timer enabled
//   PAUSE | value frozen, timer stopped (partial second is discarded)
//   ALARM | expired at 00:00, alarm held for ALARM_TICKS ticks
module countdown_ctrl
    import countdown_ctrl_pkg::*;
#(
    parameter int MAX_MIN     = 59,
    parameter int ALARM_TICKS = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       btn_start,
    input  logic       btn_clear,
    input  logic       btn_min_inc,
    input  logic       btn_sec_inc,
    output logic       run,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic       alarm,
    output logic [1:0] state
);

    localparam logic [7:0] MIN_MAX_BCD = int_to_bcd(MAX_MIN);
    localparam logic [3:0] ALARM_LAST  = 4'(ALARM_TICKS);

    state_t     state_q;
    state_t     state_d;
    logic [3:0] alarm_cnt;
    logic [3:0] alarm_cnt_d;
    logic       run_d;
    logic       alarm_d;

    logic       sec_inc;
    logic       sec_dec;
    logic       min_inc;
    logic       sec_zero;
    logic       min_zero;
    logic       sec_borrow;
    logic       min_borrow;
    logic       will_expire;
    logic       set_allowed;

    bcd_pair_counter #(.MAX(SEC_MAX)) u_sec (
        .clk     (clk),
        .rst     (rst),
        .inc     (sec_inc),
        .dec     (sec_dec),
        .clr     (btn_clear),
        .value   (sec_bcd),
        .is_zero (sec_zero),
        .borrow  (sec_borrow)
    );

    bcd_pair_counter #(.MAX(MIN_MAX_BCD)) u_min (
        .clk     (clk),
        .rst     (rst),
        .inc     (min_inc),
        .dec     (sec_borrow),
        .clr     (btn_clear),
        .value   (min_bcd),
        .is_zero (min_zero),
        .borrow  (min_borrow)
    );

    // The tick that lands on 00:01 is the one that reaches 00:00.
    assign will_expire = min_zero && (sec_bcd == 8'h01);

    // State, alarm counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            alarm_cnt <= 4'd0;
            run       <= 1'b0;
            alarm     <= 1'b0;
        end else begin
            state_q   <= state_d;
            alarm_cnt <= alarm_cnt_d;
            run       <= run_d;
            alarm     <= alarm_d;
        end
    end

    // Next-state decode; priority is clear, then tick, then start.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!btn_clear && btn_start && !(sec_zero && min_zero)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (btn_clear) begin
                    state_d = ST_IDLE;
                end else if (tick && will_expire) begin
                    state_d = ST_ALARM;
                end else if (btn_start) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (btn_clear) begin
                    state_d = ST_IDLE;
                end else if (btn_start) begin
                    state_d = ST_RUN;
                end
            end
            ST_ALARM: begin
                if (btn_clear || btn_start) begin
                    state_d = ST_IDLE;
                end else if (tick && (alarm_cnt + 4'd1 == ALARM_LAST)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Counter controls, alarm count and output decode of the next state.
    always_comb begin
        set_allowed = (state_q == ST_IDLE) && !btn_clear && !btn_start;
        sec_inc     = set_allowed && btn_sec_inc;
        min_inc     = set_allowed && btn_min_inc;
        sec_dec     = (state_q == ST_RUN) && tick && !btn_clear;

        alarm_cnt_d = 4'd0;
        if ((state_q == ST_ALARM) && (state_d == ST_ALARM)) begin
            alarm_cnt_d = tick ? alarm_cnt + 4'd1 : alarm_cnt;
        end

        run_d   = (state_d == ST_RUN) || (state_d == ST_ALARM);
        alarm_d = (state_d == ST_ALARM);
    end

    assign state = state_q;

endmodule

// File: doc/countdown_ctrl.md
Name: countdown_ctrl

Overview:
- Minutes:seconds countdown controller, downstream of the one-second period timer.
- Consumes the timer's one-cycle `flg` pulse as `tick`.
- Drives `run` back to the timer's `sig` enable input, so the timer only counts while the countdown is active.
- Holds a BCD mm:ss value for the display stage and raises `alarm` when the countdown expires.

Parameters:
- MAX_MIN, 59, highest minute value settable in IDLE (BCD-valid, 0..99); minute increment wraps from MAX_MIN to 00.
- ALARM_TICKS, 5, number of `tick` pulses `alarm` stays asserted before automatic return to IDLE (1..15).

Ports:
- clk  input  1  system clock (same domain as the period timer).
- rst  input  1  synchronous, active-high reset.
- tick  input  1  one-cycle pulse per elapsed second, from the period timer `flg`.
- btn_start  input  1  one-cycle debounced pulse; start/pause toggle.
- btn_clear  input  1  one-cycle debounced pulse; abort and zero.
- btn_min_inc  input  1  one-cycle pulse; minute +1, IDLE only.
- btn_sec_inc  input  1  one-cycle pulse; second +1, IDLE only.
- run  output  1  enable to the period timer `sig`.
- min_bcd  output  8  minutes, two BCD digits, tens in [7:4].
- sec_bcd  output  8  seconds, two BCD digits, tens in [7:4].
- alarm  output  1  expiry indication.
- state  output  2  current FSM state, for debug and LED use.

Behaviour:
- Reset (clk edge with rst=1): state=IDLE, min_bcd=8'h00, sec_bcd=8'h00, run=0, alarm=0, alarm tick count=0.
- Reset mid-operation behaves the same regardless of state.
- All outputs are registered. Each reacts on the clk edge that samples the causing input, i.e. visible one cycle after the input is presented.
- Input priority within one cycle: btn_clear > tick-driven update > btn_start > inc buttons.
- Encoding: IDLE=0, RUN=1, PAUSE=2, ALARM=3.
- IDLE (run=0, alarm=0):
  - btn_sec_inc: sec +1 in BCD; 59 -> 00; no carry into minutes.
  - btn_min_inc: min +1 in BCD; MAX_MIN -> 00.
  - Both inc buttons together: both fields update.
  - btn_clear: mm:ss = 00:00.
  - btn_start with mm:ss != 00:00: -> RUN. With 00:00: ignored, stay IDLE.
  - tick is ignored.
- RUN (run=1):
  - On tick: if sec != 00, sec -1; else sec=59 and min -1 (BCD borrow: x0 -> (x-1)9).
  - If the decrement yields 00:00: -> ALARM on the same edge, alarm tick count=0.
  - btn_start -> PAUSE.
  - Simultaneous tick + btn_start: the decrement applies, then -> PAUSE, unless the result is 00:00, in which case -> ALARM.
  - btn_clear -> IDLE with 00:00, and overrides a same-cycle tick.
  - Inc buttons are ignored.
- PAUSE (run=0):
  - Value is frozen; tick and inc buttons are ignored.
  - btn_start -> RUN.
  - btn_clear -> IDLE with 00:00.
  - Dropping run restarts the timer's period count, so the partial second in progress is discarded on resume. This is intended.
- ALARM (run=1, alarm=1, mm:ss held at 00:00):
  - Each tick increments the alarm count.
  - On the tick that makes the count equal ALARM_TICKS: -> IDLE, alarm=0, run=0.
  - btn_start or btn_clear -> IDLE immediately.
- Width rules:
  - The BCD low digit is never >9; the high seconds digit is never >5; the high minutes digit never exceeds MAX_MIN's tens digit.
  - The alarm count is 4 bits.
- run is a registered decode of state: 1 in RUN and ALARM only. It deasserts on the same edge the FSM leaves those states.

Decomposition:
- Shared package holds:
  - State encoding constants (IDLE/RUN/PAUSE/ALARM).
  - SEC_MAX=8'h59.
  - BCD digit width constant.
- One natural sub-module: bcd_pair_counter.
  - Two-digit BCD counter with parameter MAX.
  - Inputs: inc, dec, clr.
  - Outputs: value, is_zero, borrow-out on 00 -> MAX.
  - Instantiated once for seconds (MAX=59, borrow feeds the minutes dec) and once for minutes (MAX=MAX_MIN).
- The FSM stays in countdown_ctrl.

Test Plan:
- Reset with rst=1 for 2 cycles -> all outputs zero, state=0; btn_start alone afterwards -> stays IDLE, run=0.
- 3x btn_min_inc, 2x btn_sec_inc, btn_start -> mm:ss=03:02, state=RUN, run=1.
  - 3 ticks -> 02:59.
  - 60 further ticks -> 01:59.
- Load 00:02, start, 2 ticks -> on the second tick edge mm:ss=00:00, alarm=1, run=1.
  - ALARM_TICKS=5 further ticks -> alarm=0, state=IDLE, run=0.
- Set-mode wrap:
  - From 00:59, btn_sec_inc -> 00:00.
  - From MAX_MIN=59 minutes, btn_min_inc -> 00.
  - Setting 09 -> 10: sec_bcd 8'h09 -> 8'h10 (BCD carry).
- RUN at 01:00 with tick + btn_start in the same cycle -> 00:59 and PAUSE.
  - Further ticks -> no change.
  - btn_start -> RUN.
- RUN at 00:01 with tick + btn_start -> ALARM, not PAUSE.
- RUN at 00:01 with tick + btn_clear -> IDLE, 00:00, alarm=0.
- Mid-countdown rst -> IDLE, 00:00.
